// File: rtl/ahb_lite_mem_system_pkg.sv
// Shared definitions for the AHB-Lite memory subsystem: bus encodings,
// address map, slave select and the byte-lane strobe helper.
package Definitions;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        SEL_SLV0    = 2'd0,
        SEL_SLV1    = 2'd1,
        SEL_DEFAULT = 2'd2
    } sel_e;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [31:0] SLV0_BASE = 32'h0000_0000;
    localparam logic [31:0] SLV1_BASE = 32'h0000_0400;
    localparam logic [31:0] SLV_SIZE  = 32'h0000_0400;

    // Little-endian byte lanes touched by a transfer of the given size/offset.
    function automatic logic [3:0] byte_strobe(input logic [2:0] size,
                                               input logic [1:0] off);
        logic [3:0] strb;
        strb = 4'b0000;
        case (size)
            HSIZE_BYTE: strb = 4'b0001 << off;
            HSIZE_HALF: strb = off[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: strb = 4'b1111;
            default:    strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/ahb_lite_mem_system_mem_slave.sv
// One word-organised memory slave: holds the data-phase registers of the
// transfer it accepted and performs byte-lane writes / full-word reads.
module ahb_mem_slave
    import Definitions::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 256,
    parameter int IDX_W      = $clog2(MEM_WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sel_i,
    input  logic                  write_i,
    input  logic [2:0]            size_i,
    input  logic [IDX_W+1:0]      addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic                  valid_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic [IDX_W+1:0]      addr_q;
    logic [3:0]            strobe_s;
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Capture the address-phase attributes for the following data phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            addr_q  <= '0;
        end else begin
            valid_q <= sel_i;
            if (sel_i) begin
                write_q <= write_i;
                size_q  <= size_i;
                addr_q  <= addr_i;
            end
        end
    end

    // Byte lanes written at the edge that completes a write data phase.
    always_comb begin
        if (valid_q && write_q) begin
            strobe_s = byte_strobe(size_q, addr_q[1:0]);
        end else begin
            strobe_s = 4'b0000;
        end
    end

    // Memory array: no reset; a reset at the completing edge aborts the write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int b = 0; b < 4; b++) begin
                if (strobe_s[b]) begin
                    mem[addr_q[IDX_W+1:2]][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Full word returned during a read data phase, zero otherwise.
    always_comb begin
        if (valid_q && !write_q) begin
            rdata_o = mem[addr_q[IDX_W+1:2]];
        end else begin
            rdata_o = {DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/ahb_lite_mem_system.sv
// AHB-Lite subsystem top: address decoder, select store, default/error
// slave with its two-cycle ERROR FSM, and the response multiplexer.
module ahb_lite_mem_system
    import Definitions::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic                  HMASTLOCK,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADY,
    output logic                  HRESP
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    localparam logic [1:0] ST_OKAY = 2'd0;
    localparam logic [1:0] ST_ERR1 = 2'd1;
    localparam logic [1:0] ST_ERR2 = 2'd2;

    logic [1:0]            state_q, state_d;
    sel_e                  sel_q, sel_d;
    logic                  dphase_q, dphase_d;
    sel_e                  dec_sel_s;
    logic                  accept_s;
    logic                  active_s;
    logic                  misalign_s;
    logic                  err_s;
    logic                  good_s;
    logic [DATA_WIDTH-1:0] rdata0_s, rdata1_s;
    logic                  unused_s;

    // Bus attributes that are accepted but play no part in the transfer.
    assign unused_s = ^{HBURST, HPROT, HMASTLOCK};

    // Address phases are taken only while the bus is ready.
    assign accept_s = (state_q != ST_ERR1);
    assign active_s = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);

    // Address decoder for the two 1 KB memory windows.
    always_comb begin
        if ((HADDR >= SLV1_BASE) && (HADDR < (SLV1_BASE + SLV_SIZE))) begin
            dec_sel_s = SEL_SLV1;
        end else if (HADDR < (SLV0_BASE + SLV_SIZE)) begin
            dec_sel_s = SEL_SLV0;
        end else begin
            dec_sel_s = SEL_DEFAULT;
        end
    end

    // Alignment check against the transfer size.
    always_comb begin
        case (HSIZE)
            HSIZE_HALF: misalign_s = HADDR[0];
            HSIZE_WORD: misalign_s = (HADDR[1:0] != 2'b00);
            default:    misalign_s = 1'b0;
        endcase
    end

    assign err_s  = accept_s && active_s &&
                    ((dec_sel_s == SEL_DEFAULT) || (HSIZE > HSIZE_WORD) || misalign_s);
    assign good_s = accept_s && active_s && !err_s;

    // Next state of the error FSM and the select store.
    always_comb begin
        case (state_q)
            ST_OKAY: state_d = err_s ? ST_ERR1 : ST_OKAY;
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = err_s ? ST_ERR1 : ST_OKAY;
            default: state_d = ST_OKAY;
        endcase
        if (accept_s) begin
            sel_d = dec_sel_s;
        end else begin
            sel_d = sel_q;
        end
        dphase_d = good_s;
    end

    // Error FSM and select-store registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_OKAY;
            sel_q    <= SEL_DEFAULT;
            dphase_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            dphase_q <= dphase_d;
        end
    end

    assign HREADY = (state_q != ST_ERR1);
    assign HRESP  = (state_q != ST_OKAY) ? HRESP_ERROR : HRESP_OKAY;

    ahb_mem_slave #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS),
        .IDX_W      (IDX_W)
    ) u_slv0 (
        .clk     (clk),
        .reset   (reset),
        .sel_i   (good_s && (dec_sel_s == SEL_SLV0)),
        .write_i (HWRITE),
        .size_i  (HSIZE),
        .addr_i  (HADDR[IDX_W+1:0]),
        .wdata_i (HWDATA),
        .rdata_o (rdata0_s)
    );

    ahb_mem_slave #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS),
        .IDX_W      (IDX_W)
    ) u_slv1 (
        .clk     (clk),
        .reset   (reset),
        .sel_i   (good_s && (dec_sel_s == SEL_SLV1)),
        .write_i (HWRITE),
        .size_i  (HSIZE),
        .addr_i  (HADDR[IDX_W+1:0]),
        .wdata_i (HWDATA),
        .rdata_o (rdata1_s)
    );

    // Response multiplexer steered by the stored select.
    always_comb begin
        if (dphase_q && (sel_q == SEL_SLV0)) begin
            HRDATA = rdata0_s;
        end else if (dphase_q && (sel_q == SEL_SLV1)) begin
            HRDATA = rdata1_s;
        end else begin
            HRDATA = {DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_ahb_lite_mem_system.sv
// Self-checking bench: directed scenarios plus random traffic, all checked
// every cycle against a byte-addressed model of the two memories.
module tb_ahb_lite_mem_system;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] HADDR = 32'd0;
    logic [1:0]  HTRANS = 2'd0;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'd0;
    logic [2:0]  HBURST = 3'd0;
    logic [3:0]  HPROT = 4'd0;
    logic        HMASTLOCK = 1'b0;
    logic [31:0] HWDATA = 32'd0;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    always #5 clk = ~clk;

    ahb_lite_mem_system dut (
        .clk       (clk),
        .reset     (reset),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HMASTLOCK (HMASTLOCK),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    typedef struct {
        logic [1:0]  trans;
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } ap_t;

    // Transfer currently in its data phase (valid = good memory transfer).
    typedef struct {
        bit          valid;
        bit          write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } dp_t;

    logic [7:0] mem_b [0:2047];
    dp_t        dp;
    int         err_phase;
    int         total = 0;
    int         bad = 0;
    string      ctx = "start";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s/%s: got %h expected %h at %0t", ctx, tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mread(input logic [31:0] a);
        int base;
        base = int'(a[10:0]) & ~3;
        return {mem_b[base+3], mem_b[base+2], mem_b[base+1], mem_b[base]};
    endfunction

    task automatic mwrite(input dp_t d);
        int n;
        int ba;
        n = (d.size == 3'd0) ? 1 : (d.size == 3'd1) ? 2 : 4;
        for (int k = 0; k < n; k++) begin
            ba = int'(d.addr[10:0]) + k;
            mem_b[ba] = d.wdata[8*(ba%4) +: 8];
        end
    endtask

    // A transfer errors if it is active and unmapped, oversized or misaligned.
    function automatic bit is_err(input ap_t a);
        bit act;
        act = (a.trans >= 2'd2);
        if (!act) return 1'b0;
        if (a.addr >= 32'h800) return 1'b1;
        if (a.size > 3'd2) return 1'b1;
        if (a.size == 3'd1 && (a.addr % 2) != 0) return 1'b1;
        if (a.size == 3'd2 && (a.addr % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic ap_t mk(input logic [1:0] t, input logic w, input logic [31:0] a,
                               input logic [2:0] s, input logic [31:0] d);
        ap_t r;
        r.trans = t; r.write = w; r.addr = a; r.size = s; r.wdata = d;
        return r;
    endfunction

    // One bus cycle: present an address phase, check the data-phase response, advance the model.
    task automatic cycle(input ap_t ap, input bit rst);
        logic [31:0] exp_rd;
        logic        exp_rdy;
        logic        exp_rsp;
        reset     = rst;
        HTRANS    = ap.trans;
        HWRITE    = ap.write;
        HADDR     = ap.addr;
        HSIZE     = ap.size;
        HBURST    = 3'($urandom);
        HPROT     = 4'($urandom);
        HMASTLOCK = 1'($urandom);
        HWDATA    = (dp.valid && dp.write) ? dp.wdata : $urandom;
        @(negedge clk);
        if (err_phase == 1) begin
            exp_rdy = 1'b0; exp_rsp = 1'b1; exp_rd = 32'd0;
        end else if (err_phase == 2) begin
            exp_rdy = 1'b1; exp_rsp = 1'b1; exp_rd = 32'd0;
        end else begin
            exp_rdy = 1'b1; exp_rsp = 1'b0;
            exp_rd  = (dp.valid && !dp.write) ? mread(dp.addr) : 32'd0;
        end
        check("hready", {31'd0, HREADY}, {31'd0, exp_rdy});
        check("hresp",  {31'd0, HRESP},  {31'd0, exp_rsp});
        check("hrdata", HRDATA, exp_rd);
        @(posedge clk);
        if (rst) begin
            dp = '{default: 0};
            err_phase = 0;
        end else if (err_phase == 1) begin
            err_phase = 2;
        end else begin
            if (dp.valid && dp.write) mwrite(dp);
            dp.valid = (ap.trans >= 2'd2) && !is_err(ap);
            dp.write = ap.write;
            dp.addr  = ap.addr;
            dp.size  = ap.size;
            dp.wdata = ap.wdata;
            err_phase = is_err(ap) ? 1 : 0;
        end
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        cycle(mk(2'd2, 1'b1, a, s, d), 1'b0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] s);
        cycle(mk(2'd2, 1'b0, a, s, 32'd0), 1'b0);
    endtask

    task automatic idle();
        cycle(mk(2'd0, 1'b0, 32'd0, 3'd0, 32'd0), 1'b0);
    endtask

    function automatic ap_t rand_ap();
        ap_t a;
        int  r;
        r = $urandom_range(0, 9);
        if (r < 4)      a.addr = $urandom_range(0, 63);
        else if (r < 8) a.addr = 32'h400 + $urandom_range(0, 63);
        else if (r < 9) a.addr = $urandom_range(0, 32'h7FF);
        else            a.addr = $urandom;
        a.size  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
        if ($urandom_range(0, 9) < 8 && a.size <= 3'd2) a.addr = a.addr & ~((32'd1 << a.size) - 32'd1);
        r = $urandom_range(0, 5);
        a.trans = (r < 2) ? 2'(r) : ((r < 4) ? 2'd2 : 2'd3);
        a.write = 1'($urandom);
        a.wdata = $urandom;
        return a;
    endfunction

    initial begin
        dp = '{default: 0};
        err_phase = 0;
        for (int i = 0; i < 2048; i++) mem_b[i] = 8'd0;
        repeat (3) @(posedge clk);
        #1;

        ctx = "reset";
        idle();

        ctx = "init";
        for (int w = 0; w < 512; w++) wr(32'(w * 4), 3'd2, 32'd0);
        idle();

        ctx = "word_wr_rd";
        wr(32'h10, 3'd2, 32'hDEADBEEF);
        idle();
        rd(32'h10, 3'd2);
        idle();

        ctx = "byte_half";
        wr(32'h403, 3'd0, 32'hAA00_0000);
        wr(32'h400, 3'd1, 32'h0000_1234);
        rd(32'h400, 3'd2);
        idle();

        ctx = "back_to_back";
        wr(32'h20, 3'd2, 32'h11111111);
        rd(32'h20, 3'd2);
        idle();

        ctx = "unmapped";
        wr(32'h1000, 3'd2, 32'h5A5A5A5A);
        idle();
        idle();
        rd(32'h0, 3'd2);
        idle();

        ctx = "misaligned";
        rd(32'h2, 3'd2);
        idle();
        idle();

        ctx = "reset_mid";
        wr(32'h30, 3'd2, 32'hCAFEF00D);
        cycle(mk(2'd0, 1'b0, 32'd0, 3'd0, 32'd0), 1'b1);
        idle();
        rd(32'h30, 3'd2);
        idle();

        ctx = "random";
        for (int n = 0; n < 1500; n++) cycle(rand_ap(), 1'b0);
        idle();
        idle();
        idle();

        ctx = "sweep";
        for (int w = 0; w < 16; w++) rd(32'(w * 4), 3'd2);
        for (int w = 0; w < 16; w++) rd(32'h400 + 32'(w * 4), 3'd2);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
